// File: rtl/aes_pkg.sv
// Shared AES constants, GF(2^8) helper and the MixColumns engine state encoding.
package aes_pkg;

  localparam logic [7:0] AES_POLY = 8'h1B;
  localparam int         NB       = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Multiply by x in GF(2^8), reducing modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/mix_single_column.sv
// Combinational MixColumns for one 32-bit column {a0,a1,a2,a3} -> {b0,b1,b2,b3}.
module mix_single_column
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);

  logic [7:0] a0, a1, a2, a3;
  logic [7:0] x0, x1, x2, x3;

  assign a0 = col_in[31:24];
  assign a1 = col_in[23:16];
  assign a2 = col_in[15:8];
  assign a3 = col_in[7:0];

  // Each output byte is a circulant combination of 2a, 3a (= 2a ^ a) and a.
  always_comb begin
    x0 = xtime(a0);
    x1 = xtime(a1);
    x2 = xtime(a2);
    x3 = xtime(a3);
    col_out[31:24] = x0 ^ (x1 ^ a1) ^ a2 ^ a3;
    col_out[23:16] = a0 ^ x1 ^ (x2 ^ a2) ^ a3;
    col_out[15:8]  = a0 ^ a1 ^ x2 ^ (x3 ^ a3);
    col_out[7:0]   = (x0 ^ a0) ^ a1 ^ a2 ^ x3;
  end

endmodule

// File: rtl/mix_columns_seq.sv
// Column-serial MixColumns engine: IDLE accepts a block, BUSY walks the column
// groups through COLS_PER_CYCLE shared column units, DONE holds the result.
module mix_columns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_data,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_data,
  output logic         busy
);

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
      $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  // A step of 4 truncates to 0 in the 2-bit counter, which is exactly the wrap we want.
  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] CNT_LAST = 2'(NB - COLS_PER_CYCLE);

  state_e       state_q, state_d;
  logic [1:0]   col_cnt_q, col_cnt_d;
  logic [0:127] src_q, src_d;
  logic [0:127] res_q, res_d;
  logic         byp_q, byp_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic [0:127] out_data_q, out_data_d;

  logic [1:0]   col_idx [COLS_PER_CYCLE];
  logic [31:0]  col_src [COLS_PER_CYCLE];
  logic [31:0]  col_res [COLS_PER_CYCLE];

  // Unit gi always serves column col_cnt + gi of the current group.
  generate
    for (genvar gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_unit
      assign col_idx[gi] = col_cnt_q + 2'(gi);
      assign col_src[gi] = src_q[{col_idx[gi], 5'b0} +: 32];

      mix_single_column u_col (
        .col_in  (col_src[gi]),
        .col_out (col_res[gi])
      );
    end
  endgenerate

  // Next-state and datapath: flush overrides everything, then per-state behaviour.
  always_comb begin
    state_d     = state_q;
    col_cnt_d   = col_cnt_q;
    src_d       = src_q;
    res_d       = res_q;
    byp_d       = byp_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (flush) begin
      // res_q and out_data_q are left alone; out_valid low marks them stale.
      state_d     = S_IDLE;
      col_cnt_d   = 2'd0;
      out_valid_d = 1'b0;
      in_ready_d  = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          in_ready_d = 1'b1;
          if (in_valid && in_ready_q) begin
            src_d      = in_data;
            byp_d      = in_bypass;
            in_ready_d = 1'b0;
            if (in_bypass) begin
              res_d   = in_data;
              state_d = S_DONE;
            end else begin
              col_cnt_d = 2'd0;
              state_d   = S_BUSY;
            end
          end
        end

        S_BUSY: begin
          if (byp_q) begin
            // Bypass blocks go straight to DONE from IDLE; never transform one here.
            col_cnt_d = 2'd0;
            state_d   = S_DONE;
          end else begin
            for (int u = 0; u < COLS_PER_CYCLE; u++) begin
              res_d[{col_idx[u], 5'b0} +: 32] = col_res[u];
            end
            col_cnt_d = col_cnt_q + CNT_STEP;
            if (col_cnt_q == CNT_LAST) begin
              col_cnt_d = 2'd0;
              state_d   = S_DONE;
            end
          end
        end

        S_DONE: begin
          if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = S_IDLE;
          end else begin
            out_valid_d = 1'b1;
            out_data_d  = res_q;
          end
        end

        default: begin
          state_d    = S_IDLE;
          col_cnt_d  = 2'd0;
          in_ready_d = 1'b1;
        end
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      col_cnt_q   <= 2'd0;
      src_q       <= '0;
      res_q       <= '0;
      byp_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      col_cnt_q   <= col_cnt_d;
      src_q       <= src_d;
      res_q       <= res_d;
      byp_q       <= byp_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q == S_BUSY);

endmodule
